// File: rtl/lvds_arb_pkg.sv
// Shared definitions for the two-client LVDS word arbiter.
package lvds_arb_pkg;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/lvds_word_fifo.sv
// Synchronous 32-bit word FIFO with occupancy counter.
// A push on a full FIFO is taken only when a pop happens at the same edge,
// so occupancy stays at DEPTH and order is preserved.
module lvds_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty,
  output logic        empty_next
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);
  assign empty_next = (count_next == '0);
  assign head       = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lvds_tx_arbiter.sv
// Two-client round-robin arbiter feeding the LVDS transmit word port,
// with link-state tracking, drain control and per-client sent counters.
module lvds_tx_arbiter
  import lvds_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             tx_inclock,
  input  logic             reset,
  input  logic             link_up,
  input  logic [31:0]      c0_enq_put,
  input  logic             EN_c0_enq_put,
  output logic             RDY_c0_enq_put,
  input  logic [31:0]      c1_enq_put,
  input  logic             EN_c1_enq_put,
  output logic             RDY_c1_enq_put,
  output logic [31:0]      enq_tx_put,
  output logic             EN_enq_tx_put,
  input  logic             RDY_enq_tx_put,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [CNT_W-1:0] c0_sent,
  output logic [CNT_W-1:0] c1_sent
);

  arb_state_t  state;
  arb_state_t  state_d;
  logic        last_grant;
  logic        grant;
  logic        intake_open;
  logic        forward_open;
  logic        push0, push1;
  logic        pop0, pop1;
  logic [31:0] head0, head1;
  logic        full0, full1;
  logic        empty0, empty1;
  logic        empty_next0, empty_next1;

  lvds_word_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk        (tx_inclock),
    .reset      (reset),
    .push       (push0),
    .push_data  (c0_enq_put),
    .pop        (pop0),
    .head       (head0),
    .full       (full0),
    .empty      (empty0),
    .empty_next (empty_next0)
  );

  lvds_word_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk        (tx_inclock),
    .reset      (reset),
    .push       (push1),
    .push_data  (c1_enq_put),
    .pop        (pop1),
    .head       (head1),
    .full       (full1),
    .empty      (empty1),
    .empty_next (empty_next1)
  );

  assign intake_open    = (state == RUN) || (state == DOWN);
  assign forward_open   = (state == RUN) || (state == DRAIN);
  assign RDY_c0_enq_put = intake_open && !full0;
  assign RDY_c1_enq_put = intake_open && !full1;
  assign push0          = EN_c0_enq_put && RDY_c0_enq_put;
  assign push1          = EN_c1_enq_put && RDY_c1_enq_put;

  // The reset gate keeps a mid-operation reset from strobing the link in its own cycle.
  assign EN_enq_tx_put  = !reset && RDY_enq_tx_put && forward_open && (!empty0 || !empty1);
  assign pop0           = EN_enq_tx_put && (grant == CLIENT0);
  assign pop1           = EN_enq_tx_put && (grant == CLIENT1);
  assign enq_tx_put     = !EN_enq_tx_put ? 32'h0 : ((grant == CLIENT0) ? head0 : head1);

  // Grant selection: a lone non-empty FIFO wins, a tie goes to the client not granted last.
  always_comb begin
    grant = CLIENT0;
    if (empty0)      grant = CLIENT1;
    else if (empty1) grant = CLIENT0;
    else             grant = (last_grant == CLIENT1) ? CLIENT0 : CLIENT1;
  end

  // Next-state logic; losing the link overrides every other transition.
  always_comb begin
    state_d = state;
    if (!link_up) begin
      state_d = DOWN;
    end else begin
      case (state)
        DOWN:    state_d = RUN;
        RUN:     if (drain_req) state_d = DRAIN;
        DRAIN:   if (!drain_req && empty0 && empty1) state_d = RUN;
        default: state_d = DOWN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge tx_inclock) begin
    if (reset) state <= DOWN;
    else       state <= state_d;
  end

  // Grant history, saturating counters and the drain-complete flag.
  always_ff @(posedge tx_inclock) begin
    if (reset) begin
      last_grant <= CLIENT1;
      c0_sent    <= '0;
      c1_sent    <= '0;
      drain_done <= 1'b0;
    end else begin
      if (EN_enq_tx_put) last_grant <= grant;
      if (pop0 && (c0_sent != {CNT_W{1'b1}})) c0_sent <= c0_sent + CNT_W'(1);
      if (pop1 && (c1_sent != {CNT_W{1'b1}})) c1_sent <= c1_sent + CNT_W'(1);
      drain_done <= (state_d == DRAIN) && empty_next0 && empty_next1;
    end
  end

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Directed scoreboard bench for lvds_tx_arbiter.
module tb_lvds_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             tx_inclock = 1'b0;
  logic             reset;
  logic             link_up;
  logic [31:0]      c0_enq_put;
  logic             EN_c0_enq_put;
  logic             RDY_c0_enq_put;
  logic [31:0]      c1_enq_put;
  logic             EN_c1_enq_put;
  logic             RDY_c1_enq_put;
  logic [31:0]      enq_tx_put;
  logic             EN_enq_tx_put;
  logic             RDY_enq_tx_put;
  logic             drain_req;
  logic             drain_done;
  logic [CNT_W-1:0] c0_sent;
  logic [CNT_W-1:0] c1_sent;

  logic [31:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 tx_inclock = ~tx_inclock;

  lvds_tx_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .tx_inclock     (tx_inclock),
    .reset          (reset),
    .link_up        (link_up),
    .c0_enq_put     (c0_enq_put),
    .EN_c0_enq_put  (EN_c0_enq_put),
    .RDY_c0_enq_put (RDY_c0_enq_put),
    .c1_enq_put     (c1_enq_put),
    .EN_c1_enq_put  (EN_c1_enq_put),
    .RDY_c1_enq_put (RDY_c1_enq_put),
    .enq_tx_put     (enq_tx_put),
    .EN_enq_tx_put  (EN_enq_tx_put),
    .RDY_enq_tx_put (RDY_enq_tx_put),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .c0_sent        (c0_sent),
    .c1_sent        (c1_sent)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge tx_inclock);
    #1;
  endtask

  task automatic applyStimulus(input logic client, input logic [31:0] word);
    if (client == 1'b0) begin
      EN_c0_enq_put = 1'b1;
      c0_enq_put    = word;
    end else begin
      EN_c1_enq_put = 1'b1;
      c1_enq_put    = word;
    end
    tick();
    EN_c0_enq_put = 1'b0;
    EN_c1_enq_put = 1'b0;
  endtask

  task automatic pulseLink();
    RDY_enq_tx_put = 1'b1;
    tick();
    RDY_enq_tx_put = 1'b0;
    tick(3);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  // Scoreboard: every link strobe must match the next expected word.
  always @(negedge tx_inclock) begin
    logic [31:0] e;
    if (EN_enq_tx_put) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", 32'(EN_enq_tx_put), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("link_word", enq_tx_put, e);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    link_up        = 1'b0;
    c0_enq_put     = '0;
    c1_enq_put     = '0;
    EN_c0_enq_put  = 1'b0;
    EN_c1_enq_put  = 1'b0;
    RDY_enq_tx_put = 1'b0;
    drain_req      = 1'b0;

    $display("[TB] reset state");
    tick(2);
    checkOutput("rst_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    checkOutput("rst_rdy_c1", 32'(RDY_c1_enq_put), 32'd1);
    checkOutput("rst_en_tx", 32'(EN_enq_tx_put), 32'd0);
    checkOutput("rst_tx_word", enq_tx_put, 32'h0);
    checkOutput("rst_c0_sent", 32'(c0_sent), 32'd0);
    checkOutput("rst_c1_sent", 32'(c1_sent), 32'd0);
    checkOutput("rst_drain_done", 32'(drain_done), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    checkOutput("post_rst_en_tx", 32'(EN_enq_tx_put), 32'd0);

    $display("[TB] enqueue while link down");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'hC0DE_0000 + i);
    RDY_enq_tx_put = 1'b1;
    #1;
    checkOutput("down_no_strobe", 32'(EN_enq_tx_put), 32'd0);
    tick();
    RDY_enq_tx_put = 1'b0;
    tick(3);
    checkOutput("down_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hC0DE_0000 + i);
    link_up = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pulseLink();
    checkOutput("down_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("down_c0_sent", 32'(c0_sent), 32'd3);

    $display("[TB] round-robin tie");
    link_up = 1'b0;
    doReset();
    applyStimulus(1'b0, 32'hA0);
    applyStimulus(1'b0, 32'hA1);
    applyStimulus(1'b1, 32'hB0);
    applyStimulus(1'b1, 32'hB1);
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'hB0);
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hB1);
    link_up = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) pulseLink();
    checkOutput("rr_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("rr_c0_sent", 32'(c0_sent), 32'd2);
    checkOutput("rr_c1_sent", 32'(c1_sent), 32'd2);

    $display("[TB] full FIFO behaviour");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'hF000_0000 + i);
    checkOutput("full_rdy_c0", 32'(RDY_c0_enq_put), 32'd0);
    EN_c0_enq_put = 1'b1;
    c0_enq_put    = 32'hBAD0_0001;
    tick();
    EN_c0_enq_put = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hF000_0000 + i);
    RDY_enq_tx_put = 1'b1;
    EN_c0_enq_put  = 1'b1;
    c0_enq_put     = 32'hBAD0_0002;
    checkOutput("full_poppush_rdy_c0", 32'(RDY_c0_enq_put), 32'd0);
    tick();
    RDY_enq_tx_put = 1'b0;
    EN_c0_enq_put  = 1'b0;
    checkOutput("after_pop_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    tick(3);
    for (int i = 0; i < 3; i++) pulseLink();
    checkOutput("full_queue_empty", 32'(exp_q.size()), 32'd0);
    pulseLink();

    $display("[TB] drain");
    applyStimulus(1'b0, 32'h6000_0000);
    applyStimulus(1'b0, 32'h6000_0001);
    applyStimulus(1'b1, 32'h7000_0000);
    exp_q.push_back(32'h7000_0000);
    exp_q.push_back(32'h6000_0000);
    exp_q.push_back(32'h6000_0001);
    drain_req = 1'b1;
    tick();
    checkOutput("drain_rdy_c0", 32'(RDY_c0_enq_put), 32'd0);
    checkOutput("drain_rdy_c1", 32'(RDY_c1_enq_put), 32'd0);
    checkOutput("drain_done_early", 32'(drain_done), 32'd0);
    pulseLink();
    RDY_enq_tx_put = 1'b1;
    tick();
    RDY_enq_tx_put = 1'b0;
    checkOutput("drain_done_second", 32'(drain_done), 32'd0);
    tick(3);
    RDY_enq_tx_put = 1'b1;
    tick();
    RDY_enq_tx_put = 1'b0;
    checkOutput("drain_done_third", 32'(drain_done), 32'd1);
    tick(3);
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    drain_req = 1'b0;
    tick();
    checkOutput("undrain_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    checkOutput("undrain_done", 32'(drain_done), 32'd0);

    $display("[TB] early drain release");
    applyStimulus(1'b0, 32'h8000_0000);
    exp_q.push_back(32'h8000_0000);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    checkOutput("hold_drain_rdy_c0", 32'(RDY_c0_enq_put), 32'd0);
    pulseLink();
    checkOutput("release_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    checkOutput("release_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] counter saturation");
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'hB000_0000 + i);
      exp_q.push_back(32'hB000_0000 + i);
      pulseLink();
    end
    checkOutput("sat_c1_sent", 32'(c1_sent), 32'd15);
    checkOutput("sat_c0_sent", 32'(c0_sent), 32'd0);
    checkOutput("sat_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 32'h9000_0000);
    applyStimulus(1'b0, 32'h9000_0001);
    applyStimulus(1'b1, 32'h9100_0000);
    exp_q.push_back(32'h9000_0000);
    pulseLink();
    reset          = 1'b1;
    RDY_enq_tx_put = 1'b1;
    #1;
    checkOutput("reset_cycle_no_strobe", 32'(EN_enq_tx_put), 32'd0);
    tick();
    reset          = 1'b0;
    RDY_enq_tx_put = 1'b0;
    tick(3);
    checkOutput("midrst_c0_sent", 32'(c0_sent), 32'd0);
    checkOutput("midrst_c1_sent", 32'(c1_sent), 32'd0);
    checkOutput("midrst_rdy_c0", 32'(RDY_c0_enq_put), 32'd1);
    checkOutput("midrst_rdy_c1", 32'(RDY_c1_enq_put), 32'd1);
    pulseLink();
    pulseLink();
    checkOutput("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
